// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (BUSY watchdog with sticky error).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef logic port_idx_t;

  localparam int        NUM_REQ     = 2;
  localparam port_idx_t PORT_ICACHE = 1'b0;
  localparam port_idx_t PORT_DCACHE = 1'b1;

  // One-hot ack vector for a given port index.
  function automatic logic [NUM_REQ-1:0] port_onehot(input port_idx_t p);
    return (p == PORT_DCACHE) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the port that did
// not win last time is chosen; a lone request always wins.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] request,
  input  port_idx_t          last,
  output port_idx_t          grant,
  output logic               valid
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    valid = |request;
    grant = PORT_ICACHE;
    if (request == 2'b11) begin
      grant = ~last;
    end else if (request[PORT_DCACHE]) begin
      grant = PORT_DCACHE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Data_Memory port between the icache (port 0) and dcache
// (port 1) controllers. Round-robin grant, command latched for the whole
// transaction, ack/read data steered only to the granted port, and one
// dead RELEASE cycle after every transaction.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (BUSY watchdog, sticky err_o).
//
// Handshake: a requester holds req_enable_i high until it sees its
// one-cycle req_ack_o pulse and drops it by the following cycle; the
// arbiter holds mem_enable_o high from the grant edge until the cycle
// after the memory's one-cycle mem_ack_i pulse, and never raises
// mem_enable_o in the cycle immediately after an ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_enable_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]              req_ack_o,
  output logic [DATA_W-1:0]               req_data_o,
  output logic                            mem_enable_o,
  output logic                            mem_write_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [DATA_W-1:0]               mem_data_o,
  input  logic                            mem_ack_i,
  input  logic [DATA_W-1:0]               mem_data_i,
  output logic                            err_o,
  output arb_state_e                      dbg_state_o
);

  arb_state_e  state_q;
  port_idx_t   grant_q;
  port_idx_t   last_q;
  logic        mem_en_q;
  logic        cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_data_q;

  port_idx_t   pick_grant;
  logic        pick_valid;
  logic        timeout_hit;
  logic        busy_done;

  mem_arb_rr_pick u_pick (
    .request (req_enable_i),
    .last    (last_q),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_q;
  logic             err_q;

  // The limit is reached in the TIMEOUT_CYCLES-th BUSY cycle; an ack in
  // that same cycle takes priority and is treated as a normal completion.
  assign timeout_hit = (state_q == BUSY) && !mem_ack_i &&
                       (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles, restarting at every grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else if (state_q == IDLE && pick_valid) begin
      wait_q <= '0;
    end else if (state_q == BUSY) begin
      wait_q <= wait_q + CNT_W'(1);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  // A zero limit has no meaning; the watchdog itself is not built here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_bad
  end

  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign busy_done = (state_q == BUSY) && (mem_ack_i || timeout_hit);

  // Arbitration FSM with latched command and registered memory-side outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= PORT_ICACHE;
      last_q      <= PORT_DCACHE;
      mem_en_q    <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick_grant;
            last_q      <= pick_grant;
            cmd_write_q <= req_write_i[pick_grant];
            cmd_addr_q  <= req_addr_i[pick_grant];
            cmd_data_q  <= req_data_i[pick_grant];
            mem_en_q    <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (busy_done) begin
            mem_en_q <= 1'b0;
            state_q  <= RELEASE;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Steer the completion back to the granted port only; data only on a real ack.
  always_comb begin
    req_ack_o  = '0;
    req_data_o = '0;
    if (busy_done) begin
      req_ack_o = port_onehot(grant_q);
    end
    if (state_q == BUSY && mem_ack_i) begin
      req_data_o = mem_data_i;
    end
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = cmd_write_q;
  assign mem_addr_o   = cmd_addr_q;
  assign mem_data_o   = cmd_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the arbitration
// rotation plus hand-written sequences for the multi-cycle corner cases.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [1:0]            req_enable = '0;
  logic [1:0]            req_write  = '0;
  logic [1:0][AW-1:0]    req_addr   = '0;
  logic [1:0][DW-1:0]    req_data   = '0;
  logic [1:0]            req_ack;
  logic [DW-1:0]         req_rdata;
  logic                  mem_enable;
  logic                  mem_write;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic                  mem_ack   = 1'b0;
  logic [DW-1:0]         mem_rdata = '0;
  logic                  err;
  arb_state_e            dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_enable_i (req_enable),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ack_o    (req_ack),
    .req_data_o   (req_rdata),
    .mem_enable_o (mem_enable),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_rdata),
    .err_o        (err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_enable = '0;
    req_write  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Port-0 ack watcher for the single-read sequence.
  logic mon_p0 = 1'b0;
  int   p0_acks = 0;
  always @(negedge clk) begin
    if (mon_p0 && req_ack[0]) p0_acks++;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    en;
    logic          mack;
    logic [DW-1:0] mdata;
    logic [1:0]    e_ack;
    logic          e_men;
    logic [AW-1:0] e_addr;
    logic          e_wr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata;
    arb_state_e    e_state;
  } vec_t;

  localparam logic [AW-1:0] A0 = 32'h0000_1000;
  localparam logic [AW-1:0] A1 = 32'h0000_2000;
  localparam logic [DW-1:0] W0 = {8{32'hA0A0_0001}};
  localparam logic [DW-1:0] W1 = {8{32'hB1B1_0002}};
  localparam logic [DW-1:0] D1 = {8{32'hD1D1_1111}};
  localparam logic [DW-1:0] D2 = {8{32'hD2D2_2222}};
  localparam logic [DW-1:0] D3 = {8{32'hD3D3_3333}};
  localparam logic [DW-1:0] D4 = {8{32'hD4D4_4444}};

  function automatic vec_t mk(logic [1:0] en, logic mack, logic [DW-1:0] md,
                              logic [1:0] ea, logic em, logic [AW-1:0] ad, logic ew,
                              logic [DW-1:0] wd, logic [DW-1:0] rd, arb_state_e st);
    vec_t v;
    v.en = en; v.mack = mack; v.mdata = md; v.e_ack = ea; v.e_men = em;
    v.e_addr = ad; v.e_wr = ew; v.e_wdata = wd; v.e_rdata = rd; v.e_state = st;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    logic [DW-1:0] line;
    logic [DW-1:0] wline;
    int            gap;

    // Port 0 reads, port 1 writes in the rotation table.
    tbl[0]  = mk(2'b00, 0, '0, 2'b00, 0, '0, 0, '0, '0, IDLE);
    tbl[1]  = mk(2'b11, 0, '0, 2'b00, 0, '0, 0, '0, '0, IDLE);
    tbl[2]  = mk(2'b11, 0, '0, 2'b00, 1, A0, 0, W0, '0, BUSY);
    tbl[3]  = mk(2'b11, 1, D1, 2'b01, 1, A0, 0, W0, D1, BUSY);
    tbl[4]  = mk(2'b11, 0, '0, 2'b00, 0, '0, 0, '0, '0, RELEASE);
    tbl[5]  = mk(2'b11, 0, '0, 2'b00, 0, '0, 0, '0, '0, IDLE);
    tbl[6]  = mk(2'b11, 0, D4, 2'b00, 1, A1, 1, W1, '0, BUSY);
    tbl[7]  = mk(2'b11, 1, D2, 2'b10, 1, A1, 1, W1, D2, BUSY);
    tbl[8]  = mk(2'b11, 1, D4, 2'b00, 0, '0, 0, '0, '0, RELEASE);
    tbl[9]  = mk(2'b11, 0, '0, 2'b00, 0, '0, 0, '0, '0, IDLE);
    tbl[10] = mk(2'b00, 0, '0, 2'b00, 1, A0, 0, W0, '0, BUSY);
    tbl[11] = mk(2'b00, 0, '0, 2'b00, 1, A0, 0, W0, '0, BUSY);
    tbl[12] = mk(2'b00, 1, D3, 2'b01, 1, A0, 0, W0, D3, BUSY);
    tbl[13] = mk(2'b00, 0, '0, 2'b00, 0, '0, 0, '0, '0, RELEASE);
    tbl[14] = mk(2'b00, 1, D4, 2'b00, 0, '0, 0, '0, '0, IDLE);
    tbl[15] = mk(2'b00, 0, '0, 2'b00, 0, '0, 0, '0, '0, IDLE);

    // ---- reset values ----
    rst = 1'b1;
    #3;
    chk("rst_men",   mem_enable, 0);
    chk("rst_wr",    mem_write, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ack",   req_ack, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_err",   err, 0);
    chk("rst_state", dbg_state, IDLE);
    do_reset();

    // ---- rotation table ----
    req_addr[0] = A0; req_addr[1] = A1;
    req_data[0] = W0; req_data[1] = W1;
    req_write   = 2'b10;
    for (int i = 0; i < 16; i++) begin
      req_enable = tbl[i].en;
      mem_ack    = tbl[i].mack;
      mem_rdata  = tbl[i].mdata;
      #1;
      chk($sformatf("v%0d_ack", i),   req_ack,    tbl[i].e_ack);
      chk($sformatf("v%0d_rdata", i), req_rdata,  tbl[i].e_rdata);
      chk($sformatf("v%0d_men", i),   mem_enable, tbl[i].e_men);
      chk($sformatf("v%0d_state", i), dbg_state,  tbl[i].e_state);
      if (tbl[i].e_men) begin
        chk($sformatf("v%0d_addr", i),  mem_addr,  tbl[i].e_addr);
        chk($sformatf("v%0d_wr", i),    mem_write, tbl[i].e_wr);
        chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      tick();
    end

    // ---- single read on port 1, ack after 10 cycles ----
    do_reset();
    line = {4{64'hECFA_5A5A_0F0F_C3C3}};
    req_write = 2'b00;
    req_addr[1] = 32'h0000_0040;
    req_enable = 2'b10;
    p0_acks = 0;
    mon_p0 = 1'b1;
    tick();
    chk("rd_men",  mem_enable, 1);
    chk("rd_addr", mem_addr, 32'h0000_0040);
    chk("rd_wr",   mem_write, 0);
    for (int c = 1; c < 10; c++) begin
      chk($sformatf("rd_wait%0d_ack", c), req_ack, 0);
      tick();
    end
    mem_ack = 1'b1;
    mem_rdata = line;
    exp_q.push_back(line);
    #1;
    chk("rd_ack", req_ack, 2'b10);
    if (exp_q.size() > 0) chk("rd_data", req_rdata, exp_q.pop_front());
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    req_enable = 2'b00;
    #1;
    chk("rd_ack_once", req_ack, 0);
    tick();
    tick();
    mon_p0 = 1'b0;
    chk("rd_p0_never", p0_acks, 0);

    // ---- write latching on port 0 ----
    do_reset();
    wline = {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};
    req_write = 2'b01;
    req_addr[0] = 32'h0000_0200;
    req_data[0] = wline;
    req_enable = 2'b01;
    tick();
    req_addr[0] = 32'hDEAD_BEE0;
    req_data[0] = ~wline;
    req_write = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("wl%0d_addr", c), mem_addr, 32'h0000_0200);
      chk($sformatf("wl%0d_data", c), mem_wdata, wline);
      chk($sformatf("wl%0d_wr", c),   mem_write, 1);
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chk("wl_ack", req_ack, 2'b01);
    chk("wl_ack_addr", mem_addr, 32'h0000_0200);
    tick();
    mem_ack = 1'b0;
    req_enable = 2'b00;

    // ---- back-to-back: port 0 waits while port 1 completes ----
    do_reset();
    req_write = 2'b00;
    req_addr[1] = 32'h0000_3000;
    req_addr[0] = 32'h0000_4000;
    req_enable = 2'b10;
    tick();
    req_enable = 2'b11;
    tick();
    chk("bb_p1_addr", mem_addr, 32'h0000_3000);
    mem_ack = 1'b1;
    mem_rdata = D1;
    #1;
    chk("bb_ack", req_ack, 2'b10);
    tick();
    mem_ack = 1'b0;
    req_enable = 2'b01;
    gap = 0;
    while (!mem_enable && gap < 10) begin
      gap++;
      tick();
    end
    chk("bb_gap", gap, 2);
    chk("bb_p0_addr", mem_addr, 32'h0000_4000);
    mem_ack = 1'b1;
    #1;
    chk("bb_p0_ack", req_ack, 2'b01);
    tick();
    mem_ack = 1'b0;
    req_enable = 2'b00;

    // ---- async reset in the middle of BUSY ----
    do_reset();
    req_addr[0] = 32'h0000_5000;
    req_addr[1] = 32'h0000_6000;
    req_enable = 2'b10;
    tick();
    chk("ar_busy", mem_enable, 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_men_drop", mem_enable, 0);
    chk("ar_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_enable = 2'b11;
    tick();
    chk("ar_tie_men", mem_enable, 1);
    chk("ar_tie_p0", mem_addr, 32'h0000_5000);
    mem_ack = 1'b1;
    #1;
    chk("ar_tie_ack", req_ack, 2'b01);
    tick();
    mem_ack = 1'b0;
    req_enable = 2'b00;

    // ---- memory never acks ----
    do_reset();
    req_enable = 2'b01;
    mem_rdata = D4;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("to_c%0d_ack", c), req_ack, 0);
      tick();
    end
    chk("to_ack", req_ack, 2'b01);
    chk("to_rdata", req_rdata, 0);
    tick();
    req_enable = 2'b00;
    chk("to_err", err, 1);
    chk("to_release", mem_enable, 0);
    repeat (5) tick();
    chk("to_err_held", err, 1);
`else
    gap = 0;
    for (int c = 0; c < 200; c++) begin
      if (req_ack != 2'b00) gap++;
      tick();
    end
    chk("nto_men", mem_enable, 1);
    chk("nto_no_ack", gap, 0);
    chk("nto_err", err, 0);
`endif
    do_reset();
    chk("final_err", err, 0);
    chk("final_men", mem_enable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
